// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes, ALU codes and mux selects.
package riscv_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecuteR = 4'd6;
  localparam state_t StAluWb    = 4'd7;
  localparam state_t StExecuteI = 4'd8;
  localparam state_t StJal      = 4'd9;
  localparam state_t StBeq      = 4'd10;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op and the instruction fields.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Only R-type (op5=1) with bit 30 set subtracts; addi ignores bit 30.
  always_comb begin
    alu_control_o = AluAdd;
    case (alu_op_i)
      AluOpSub: alu_control_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluAdd;
        endcase
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic [3:0] o_state
);

  state_t     state_q, state_d;
  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [2:0] alu_control;

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= StFetch;
    else          state_q <= state_d;
  end

  // Next-state and Moore control decode.
  always_comb begin
    state_d    = StFetch;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBReg;
    alu_op     = AluOpAdd;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluRes;
        pc_update  = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (i_op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        state_d   = (i_op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcAReg;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: reg_write = 1'b1;
      StExecuteI: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = SrcAReg;
        alu_op    = AluOpSub;
        branch    = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (i_op)
      OpStore: imm_src = ImmS;
      OpBeq:   imm_src = ImmB;
      OpJal:   imm_src = ImmJ;
      default: imm_src = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (i_funct3),
    .op5_i         (i_op[5]),
    .funct7b5_i    (i_funct7b5),
    .alu_control_o (alu_control)
  );

  // Reset holds every output at zero, even before the first clock edge lands.
  always_comb begin
    o_pc_write    = i_rst_n & (pc_update | (branch & i_zero));
    o_adr_src     = i_rst_n & adr_src;
    o_mem_write   = i_rst_n & mem_write;
    o_ir_write    = i_rst_n & ir_write;
    o_reg_write   = i_rst_n & reg_write;
    o_result_src  = i_rst_n ? result_src : 2'b00;
    o_alu_src_a   = i_rst_n ? alu_src_a : 2'b00;
    o_alu_src_b   = i_rst_n ? alu_src_b : 2'b00;
    o_imm_src     = i_rst_n ? imm_src : 2'b00;
    o_alu_control = i_rst_n ? alu_control : 3'b000;
    o_state       = i_rst_n ? state_q : 4'd0;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions against a per-instruction model.
module tb_multicycle_controller;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [6:0] i_op = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_funct7b5 = 1'b0;
  logic       i_zero = 1'b0;
  logic       o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src;
  logic [2:0] o_alu_control;
  logic [3:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_op          (i_op),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .i_zero        (i_zero),
    .o_pc_write    (o_pc_write),
    .o_adr_src     (o_adr_src),
    .o_mem_write   (o_mem_write),
    .o_ir_write    (o_ir_write),
    .o_reg_write   (o_reg_write),
    .o_result_src  (o_result_src),
    .o_alu_src_a   (o_alu_src_a),
    .o_alu_src_b   (o_alu_src_b),
    .o_imm_src     (o_imm_src),
    .o_alu_control (o_alu_control),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  // Instruction kinds: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
  function automatic int kind_of(input logic [6:0] op);
    case (op)
      LW: return 0;
      SW: return 1;
      RT: return 2;
      IT: return 3;
      JL: return 4;
      BQ: return 5;
      default: return 6;
    endcase
  endfunction

  // ALU operation the instruction's execute cycle should request.
  function automatic logic [2:0] exec_alu(input int kind, input logic [2:0] f3, input logic f7);
    if (kind == 5) return 3'b001;
    case (f3)
      3'd0: return (kind == 2 && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int kind);
    case (kind)
      1: return 2'b01;
      5: return 2'b10;
      4: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Enter with state FETCH during the low clock phase; leave the same way after the instruction.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z);
    int kind, n;
    int path[$];
    logic [4:0] exp_en;
    logic [2:0] exp_alu;
    logic       last;
    kind = kind_of(op);
    case (kind)
      0: path = '{0, 1, 2, 3, 4};
      1: path = '{0, 1, 2, 5};
      2: path = '{0, 1, 6, 7};
      3: path = '{0, 1, 8, 7};
      4: path = '{0, 1, 9, 7};
      5: path = '{0, 1, 10};
      default: path = '{0, 1};
    endcase
    n = path.size();
    i_op = op; i_funct3 = f3; i_funct7b5 = f7; i_zero = z;
    #1;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      // {pc_write, mem_write, ir_write, reg_write, adr_src}
      exp_en[4] = (k == 0) || (kind == 4 && k == 2) || (kind == 5 && k == 2 && z);
      exp_en[3] = (kind == 1 && k == 3);
      exp_en[2] = (k == 0);
      exp_en[1] = last && (kind <= 4) && (kind != 1);
      exp_en[0] = (kind <= 1 && k == 3);
      exp_alu = ((kind == 2 || kind == 3 || kind == 5) && k == 2) ? exec_alu(kind, f3, f7)
                                                                 : 3'b000;
      n_checks++;
      if (o_state !== 4'(path[k])) begin
        n_errors++;
        $display("FAIL state op=%b k=%0d got %0d want %0d", op, k, o_state, path[k]);
      end
      n_checks++;
      if ({o_pc_write, o_mem_write, o_ir_write, o_reg_write, o_adr_src} !== exp_en) begin
        n_errors++;
        $display("FAIL enables op=%b k=%0d z=%b got %b want %b", op, k, z,
                 {o_pc_write, o_mem_write, o_ir_write, o_reg_write, o_adr_src}, exp_en);
      end
      n_checks++;
      if (o_alu_control !== exp_alu) begin
        n_errors++;
        $display("FAIL alu_control op=%b f3=%b f7=%b k=%0d got %b want %b", op, f3, f7, k,
                 o_alu_control, exp_alu);
      end
      n_checks++;
      if (o_imm_src !== imm_of(kind)) begin
        n_errors++;
        $display("FAIL imm_src op=%b got %b want %b", op, o_imm_src, imm_of(kind));
      end
      if (exp_en[1]) begin
        n_checks++;
        if (o_result_src !== ((kind == 0) ? 2'b01 : 2'b00)) begin
          n_errors++;
          $display("FAIL wb_result_src op=%b got %b", op, o_result_src);
        end
      end
      if (k == 0) begin
        n_checks++;
        if ({o_result_src, o_alu_src_a, o_alu_src_b} !== 6'b10_00_10) begin
          n_errors++;
          $display("FAIL fetch_selects got %b want 100010", {o_result_src, o_alu_src_a,
                   o_alu_src_b});
        end
      end
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write, o_result_src,
         o_alu_src_a, o_alu_src_b, o_imm_src, o_alu_control, o_state} !== 22'd0) begin
      n_errors++;
      $display("FAIL %s outputs got %b want all zero", tag,
               {o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write, o_result_src,
                o_alu_src_a, o_alu_src_b, o_imm_src, o_alu_control, o_state});
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_op = BQ;
    repeat (2) @(negedge i_clk);
    #1;
    check_all_zero("reset_hold");
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({o_ir_write, o_pc_write, o_alu_src_b, o_state} !== 8'b1_1_10_0000) begin
      n_errors++;
      $display("FAIL reset_release got %b want 11100000", {o_ir_write, o_pc_write,
               o_alu_src_b, o_state});
    end
  endtask

  task automatic test_directed();
    run_instr(LW, 3'd2, 1'b0, 1'b0);
    run_instr(RT, 3'd0, 1'b1, 1'b0);
    run_instr(RT, 3'd0, 1'b0, 1'b0);
    run_instr(IT, 3'd0, 1'b1, 1'b0);
    run_instr(IT, 3'd6, 1'b0, 1'b0);
    run_instr(IT, 3'd2, 1'b0, 1'b0);
    run_instr(RT, 3'd7, 1'b0, 1'b1);
    run_instr(SW, 3'd2, 1'b0, 1'b1);
    run_instr(JL, 3'd0, 1'b1, 1'b0);
    run_instr(BQ, 3'd0, 1'b0, 1'b1);
    run_instr(BQ, 3'd0, 1'b0, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b1);
  endtask

  // Abandon a lw in MEMREAD: next edge must land in FETCH with no write ever asserted.
  task automatic test_reset_mid();
    i_op = LW; i_funct3 = 3'd2; i_funct7b5 = 1'b0; i_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (o_mem_write !== 1'b0 || o_reg_write !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_reset_writes k=%0d got %b%b want 00", k, o_mem_write, o_reg_write);
      end
      @(negedge i_clk);
    end
    #1;
    n_checks++;
    if (o_state !== 4'd3) begin
      n_errors++;
      $display("FAIL mid_reset_reach got %0d want 3", o_state);
    end
    i_rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_forced");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({o_state, o_mem_write, o_reg_write, o_ir_write} !== 7'b0000_001) begin
      n_errors++;
      $display("FAIL mid_reset_fetch got %b want 0000001", {o_state, o_mem_write, o_reg_write,
               o_ir_write});
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[6] = '{LW, SW, RT, IT, JL, BQ};
    logic [6:0] op;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        do op = 7'($urandom); while (kind_of(op) != 6);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
